// File: rtl/keypad_debouncer.sv
// Keypad encoder: synchronises a raw one-hot keypad, debounces press/release,
// encodes the accepted key to binary and emits one active-low load strobe per
// press, with optional auto-repeat while the same key stays held.
// Ports:
//   clk, reset    : single clock, synchronous active-high reset
//   keypad        : raw asynchronous key lines, bit i = key value i, 1 = pressed
//   enablen       : active-low enable, sampled directly
//   D             : registered binary code of the last accepted key
//   loadn         : registered active-low strobe, one cycle per press or repeat
//   multi_err     : registered, high while the synchronised keypad has >1 bit set
module keypad_debouncer #(
   parameter int  NUM_KEYS        = 10,
   parameter int  DEBOUNCE_CYCLES = 4,
   parameter int  REPEAT_CYCLES   = 0,
   localparam int CODE_W          = $clog2(NUM_KEYS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] keypad,
   input  logic                enablen,
   output logic [CODE_W-1:0]   D,
   output logic                loadn,
   output logic                multi_err
);

   // Counters only ever hold 0..N-1, so clog2(N) bits suffice (min 1 bit).
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0]    RPT_LAST = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
   localparam logic [NUM_KEYS-1:0] ONE      = {{(NUM_KEYS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] s1_q, s2_q;
   logic [NUM_KEYS-1:0] cap_q, cap_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RPT_W-1:0]    rpt_q, rpt_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                loadn_q, loadn_d;
   logic                multi_q, multi_d;

   logic                s2_zero;
   logic                s2_onehot;
   logic [CODE_W-1:0]   cap_code;

   // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
   assign s2_zero   = (s2_q == '0);
   assign s2_onehot = !s2_zero && ((s2_q & (s2_q - ONE)) == '0);
   assign multi_d   = !s2_zero && !s2_onehot;

   // cap only ever holds a one-hot pattern, so a simple priority scan is exact.
   always_comb begin
      cap_code = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (cap_q[i]) begin
            cap_code = CODE_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      code_d  = code_q;
      loadn_d = 1'b1;

      if (enablen) begin
         // Disabled: park in IDLE so a key still held on re-enable is
         // debounced as a fresh press.
         state_d = IDLE;
         cnt_d   = '0;
         rpt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               rpt_d = '0;
               if (s2_onehot) begin
                  cap_d   = s2_q;
                  state_d = DEBOUNCE;
               end
            end

            DEBOUNCE: begin
               if (s2_q != cap_q) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  code_d  = cap_code;
                  loadn_d = 1'b0;
                  state_d = HELD;
                  cnt_d   = '0;
                  rpt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            HELD: begin
               if (s2_zero) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
                  rpt_d   = '0;
               end else if (s2_q == cap_q) begin
                  if (REPEAT_CYCLES > 0) begin
                     if (rpt_q == RPT_LAST) begin
                        loadn_d = 1'b0;
                        rpt_d   = '0;
                     end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                     end
                  end
               end else begin
                  // Another key or a chord while held: no new key is accepted
                  // until a full release, and repeat restarts from scratch.
                  rpt_d = '0;
               end
            end

            RELEASE: begin
               if (!s2_zero) begin
                  // Bounce on release: return to HELD silently.
                  state_d = HELD;
                  cnt_d   = '0;
                  rpt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               rpt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         state_q <= IDLE;
         cap_q   <= '0;
         cnt_q   <= '0;
         rpt_q   <= '0;
         code_q  <= '0;
         loadn_q <= 1'b1;
         multi_q <= 1'b0;
      end else begin
         s1_q    <= keypad;
         s2_q    <= s1_q;
         state_q <= state_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
         rpt_q   <= rpt_d;
         code_q  <= code_d;
         loadn_q <= loadn_d;
         multi_q <= multi_d;
      end
   end

   assign D         = code_q;
   assign loadn     = loadn_q;
   assign multi_err = multi_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Testbench for keypad_debouncer: a cycle table on the default build plus
// directed sequences for bounce, auto-repeat, key roll-over and reset.
// Two instances share stimulus: defaults, and REPEAT_CYCLES = 8.
module tb_keypad_debouncer;

   logic       clk;
   logic       reset;
   logic [9:0] keypad;
   logic       enablen;

   logic [3:0] D_a, D_r;
   logic       loadn_a, loadn_r;
   logic       multi_a, multi_r;

   int checks;
   int errors;

   keypad_debouncer u_dut (
      .clk       (clk),
      .reset     (reset),
      .keypad    (keypad),
      .enablen   (enablen),
      .D         (D_a),
      .loadn     (loadn_a),
      .multi_err (multi_a)
   );

   keypad_debouncer #(.REPEAT_CYCLES(8)) u_dut_rpt (
      .clk       (clk),
      .reset     (reset),
      .keypad    (keypad),
      .enablen   (enablen),
      .D         (D_r),
      .loadn     (loadn_r),
      .multi_err (multi_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [9:0] kp;
      logic       en;
      logic       rst;
      logic [3:0] d;
      logic       ld;
      logic       me;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int n, input logic [9:0] kp, input logic en, input logic rst,
                      input logic [3:0] d, input logic ld, input logic me);
      vec_t v;
      v.kp = kp; v.en = en; v.rst = rst; v.d = d; v.ld = ld; v.me = me;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      keypad  = '0;
      enablen = 1'b0;
      reset   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      tick();
   endtask

   logic [9:0] k1, k3, k4, k8, k9;
   int         strobes, strobes_a;

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      enablen = 1'b0;
      keypad  = '0;
      k1 = 10'b0000000010;
      k3 = 10'b0000001000;
      k4 = 10'b0000010000;
      k8 = 10'b0100000000;
      k9 = 10'b1000000000;

      // count, keypad, enablen, reset, D, loadn, multi_err
      add(2,   10'h006, 0, 1, 4'd0, 1, 0);   // reset wins over a chord at the pins
      add(3,   10'h000, 0, 0, 4'd0, 1, 0);
      add(6,   10'h020, 0, 0, 4'd0, 1, 0);   // key 5, edges 0..5
      add(1,   10'h020, 0, 0, 4'd5, 0, 0);   // strobe after edge 6
      add(100, 10'h020, 0, 0, 4'd5, 1, 0);   // long hold: no repeat by default
      add(8,   10'h000, 0, 0, 4'd5, 1, 0);   // release
      add(2,   10'h006, 0, 0, 4'd5, 1, 0);   // keys 1+2: flag after 3rd edge
      add(6,   10'h006, 0, 0, 4'd5, 1, 1);
      add(2,   10'h000, 0, 0, 4'd5, 1, 1);
      add(6,   10'h000, 0, 0, 4'd5, 1, 0);
      add(12,  10'h080, 1, 0, 4'd5, 1, 0);   // key 7 while disabled
      add(4,   10'h080, 0, 0, 4'd5, 1, 0);   // re-enabled with key held
      add(1,   10'h080, 0, 0, 4'd7, 0, 0);
      add(2,   10'h080, 0, 0, 4'd7, 1, 0);
      add(8,   10'h000, 0, 0, 4'd7, 1, 0);

      foreach (tbl[i]) begin
         keypad  = tbl[i].kp;
         enablen = tbl[i].en;
         reset   = tbl[i].rst;
         tick();
         chk($sformatf("vec%0d_D", i), D_a, tbl[i].d);
         chk($sformatf("vec%0d_loadn", i), loadn_a, tbl[i].ld);
         chk($sformatf("vec%0d_multi", i), multi_a, tbl[i].me);
      end

      // Bounce: key 3 on/off every 2 cycles, then held.
      do_reset();
      strobes = 0;
      for (int c = 0; c < 20; c++) begin
         keypad = (((c / 2) % 2) == 0) ? k3 : 10'h000;
         tick();
         if (!loadn_a) strobes++;
      end
      chk("bounce_quiet", strobes, 0);
      keypad = k3;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("bounce_loadn", loadn_a, (k == 6) ? 0 : 1);
         if (k == 6) chk("bounce_D", D_a, 3);
      end

      // Auto-repeat: key 9 held for 40 edges.
      do_reset();
      keypad    = k9;
      strobes_a = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("repeat_loadn", loadn_r, (k >= 6 && ((k - 6) % 8) == 0) ? 0 : 1);
         if (k >= 6 && ((k - 6) % 8) == 0) chk("repeat_D", D_r, 9);
         if (!loadn_a) strobes_a++;
      end
      chk("norepeat_count", strobes_a, 1);

      // Second key while holding key 1.
      do_reset();
      keypad = k1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 6) begin
            chk("hold1_loadn", loadn_a, 0);
            chk("hold1_D", D_a, 1);
         end
      end
      keypad  = k1 | k4;
      strobes = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!loadn_a) strobes++;
      end
      chk("rollover_multi", multi_a, 1);
      keypad = k4;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!loadn_a) strobes++;
      end
      keypad = '0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!loadn_a) strobes++;
      end
      chk("rollover_quiet", strobes, 0);
      chk("rollover_D_kept", D_a, 1);
      keypad = k4;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("fresh4_loadn", loadn_a, (k == 6) ? 0 : 1);
         if (k == 6) chk("fresh4_D", D_a, 4);
      end

      // Reset mid-DEBOUNCE: key 8 pressed, reset after edge 3.
      keypad = '0;
      for (int k = 0; k < 10; k++) tick();
      keypad = k8;
      for (int k = 0; k < 4; k++) tick();
      reset = 1'b1;
      tick();
      chk("rst_D", D_a, 0);
      chk("rst_loadn", loadn_a, 1);
      chk("rst_multi", multi_a, 0);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("after_rst_loadn", loadn_a, (k == 6) ? 0 : 1);
         chk("after_rst_D", D_a, (k >= 6) ? 8 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/keypad_debouncer.md
# keypad_debouncer

Parametrised, clocked keypad encoder for the microwave front panel, replacing the purely combinational one-hot encoder. It synchronises a raw one-hot keypad bus, debounces press and release, and encodes the pressed key to a binary digit. It emits exactly one active-low `loadn` strobe per accepted press, plus optional auto-repeat strobes while a key is held. Multi-key presses are rejected and flagged. It sits between the panel keypad pins and the digit-entry logic that consumes `D`/`loadn`.

## Interface
- `NUM_KEYS`, 10: width of `keypad`, legal range 2 or more; bit i is key value i.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a press or a release, legal range 1 or more.
- `REPEAT_CYCLES`, 0: auto-repeat period in cycles while a key is held; 0 disables auto-repeat.
- `CODE_W` (localparam): `$clog2(NUM_KEYS)`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keypad`  in  NUM_KEYS  raw, asynchronous key lines, one bit per key, 1 = pressed.
- `enablen`  in  1  active-low enable; sampled directly, not synchronised.
- `D`  out  CODE_W  registered binary code of the last accepted key.
- `loadn`  out  1  registered active-low strobe, low for one cycle per accepted press or repeat.
- `multi_err`  out  1  registered; high while the synchronised keypad has more than one bit set.

## Operation
- **Input path:** a two-flop synchroniser (`s1` -> `s2`) feeds `keypad`. The FSM and `multi_err` act only on `s2`.
- **Key classification:** `s2` is "valid" when exactly one bit is set, "zero" when no bit is set, and "multi" otherwise.
- **FSM states:** IDLE, DEBOUNCE, HELD, RELEASE. A debounce counter `cnt` and a repeat counter `rpt` are reset on every state entry.
- **IDLE:**
  - On a valid `s2`, capture the pattern into `cap` and go to DEBOUNCE.
  - On zero or multi `s2`, stay in IDLE.
- **DEBOUNCE:**
  - If `s2 != cap`, go back to IDLE. No strobe.
  - Otherwise increment `cnt`.
  - When `cnt == DEBOUNCE_CYCLES-1`, register `D <=` index of the set bit in `cap`, drive `loadn <= 0`, and go to HELD.
- **HELD:**
  - If `s2` is zero, go to RELEASE.
  - If `s2 == cap` and `REPEAT_CYCLES > 0`, increment `rpt`. When `rpt == REPEAT_CYCLES-1`, drive `loadn <= 0`, set `rpt <= 0`, and keep `D` unchanged.
  - If `s2` differs from `cap` but is nonzero (another key or multi), stay in HELD with repeat suspended (`rpt` cleared). No new key is ever accepted until a full release.
- **RELEASE:**
  - If `s2` is nonzero, go back to HELD with no strobe. This bounce on release is ignored.
  - If `s2` is zero, increment `cnt`. When `cnt == DEBOUNCE_CYCLES-1`, go to IDLE.
- **`loadn`** is high in every cycle not explicitly strobed above.
- **`enablen = 1`:**
  - Forces the FSM to IDLE and clears the counters.
  - Holds `loadn` high and `D` at its last value.
  - The synchroniser and `multi_err` keep running.
  - Deasserting `enablen` while a key is held makes that key eligible for a fresh press, going through IDLE -> DEBOUNCE.
- **`multi_err`** is registered from `s2`, one cycle after `s2` updates, independent of the FSM and `enablen`.
- **Reset** (takes priority over everything):
  - `s1`, `s2`, `cap` and the counters clear to 0; the FSM goes to IDLE.
  - Outputs: `D = 0`, `loadn = 1`, `multi_err = 0`.
  - A reset asserted mid-press or mid-strobe cuts the strobe and requires a fresh debounced press afterwards.

## Timing
- Edge numbering: a key is held stable from before edge 0. Edge 0 loads `s1`, edge 1 loads `s2`, and edge 2 is the IDLE -> DEBOUNCE transition.
- `loadn` goes low after edge `2+DEBOUNCE_CYCLES` and returns high after edge `3+DEBOUNCE_CYCLES`. `D` is valid from the same edge that `loadn` falls and stays stable afterwards.
- Auto-repeat: the strobe after the initial one falls exactly `REPEAT_CYCLES` edges after the previous strobe fell, for as long as the same key is held.
- Release: after the keys clear at the input, IDLE is re-entered at edge `2+DEBOUNCE_CYCLES` relative to the clear. The earliest next press strobe is therefore `2×(DEBOUNCE_CYCLES+2)` cycles after the release began, give or take one cycle.
- `multi_err` follows the `keypad` input with 3 cycles of latency.

## Test plan
- **Clean press, defaults:** `keypad = 10'b0000100000` held from edge 0 -> `loadn` low only in the cycle after edge 6, `D = 5`; the key held 100 cycles gives no further strobe; after release, `loadn` stays high.
- **Bounce:** key 3 toggled on/off every 2 cycles for 20 cycles, then held -> no strobe during bouncing; exactly one strobe with `D = 3`, 6 edges after the hold begins.
- **Auto-repeat** (`REPEAT_CYCLES = 8`): key 9 held for 40 cycles -> strobes at edges 6, 14, 22, 30, 38, all with `D = 9`.
- **Multi-key:** keys 1 and 2 pressed together -> `multi_err` high 3 cycles later, no strobe, and `D` holds its previous value.
- **Second key while holding** key 1 (after its strobe): key 4 added, then key 1 released -> no strobe for key 4 until all keys are released and key 4 is pressed fresh.
- **Disable and reset:** `enablen = 1` during a press -> no strobe. Reset pulse mid-DEBOUNCE -> `D = 0`, `loadn = 1`, and a full debounce period is needed before the next strobe.
